// File: rtl/trigger_actor_responder_if.sv
// Block-level start handshake plus the two FIFO ports of the trigger actor.
// "master" is the trigger/FIFO side, "slave" is the actor itself.
interface trigger_actor_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ap_start;
  logic                  ap_done;
  logic                  ap_idle;
  logic                  ap_ready;
  logic [31:0]           ap_return;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty_n;
  logic                  in_read;
  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_full_n;
  logic                  out_write;
  logic [31:0]           total_firings;

  modport master (
    output ap_start, in_dout, in_empty_n, out_full_n,
    input  ap_done, ap_idle, ap_ready, ap_return,
           in_read, out_din, out_write, total_firings
  );

  modport slave (
    input  ap_start, in_dout, in_empty_n, out_full_n,
    output ap_done, ap_idle, ap_ready, ap_return,
           in_read, out_din, out_write, total_firings
  );
endinterface

// File: rtl/trigger_actor_responder.sv
// Test actor beneath a trigger: on each ap_start it forwards up to MAX_FIRINGS
// tokens from a FWFT input FIFO to an output FIFO, adding OFFSET to each, and
// reports why it stopped with a trigger return code on ap_return.
module trigger_actor_responder #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MAX_FIRINGS = 16,
  parameter logic [DATA_WIDTH-1:0] OFFSET      = {DATA_WIDTH{1'b0}}
) (
  input logic                      ap_clk,
  input logic                      ap_rst,
  trigger_actor_responder_if.slave bus
);

  localparam int              CW    = $clog2(MAX_FIRINGS + 1);
  localparam logic [CW-1:0]   MAX_C = CW'(MAX_FIRINGS);

  // Trigger return codes
  localparam logic [31:0] RC_IDLE     = 32'd0;
  localparam logic [31:0] RC_WAIT     = 32'd1;
  localparam logic [31:0] RC_TEST     = 32'd2;
  localparam logic [31:0] RC_EXECUTED = 32'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     ret_q;
  logic [31:0]     total_q;
  logic            done_q;
  logic            idle_q;

  logic            fire;
  logic [31:0]     ret_d;

  // Fire decision and termination code for the current S_FIRE cycle; a cycle
  // with reset asserted never moves tokens.
  always_comb begin
    fire  = 1'b0;
    ret_d = RC_IDLE;
    if (!ap_rst && (state_q == S_FIRE) && bus.in_empty_n && bus.out_full_n &&
        (count_q < MAX_C)) begin
      fire = 1'b1;
    end else begin
      fire = 1'b0;
    end
    if ((count_q == MAX_C) && bus.in_empty_n) begin
      ret_d = RC_TEST;       // budget exhausted with work left: caller retests
    end else if (count_q != {CW{1'b0}}) begin
      ret_d = RC_EXECUTED;
    end else if (bus.in_empty_n) begin
      ret_d = RC_WAIT;       // data present but output blocked
    end else begin
      ret_d = RC_IDLE;
    end
  end

  // Invocation FSM with registered handshake outputs and firing counters.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      count_q <= {CW{1'b0}};
      ret_q   <= RC_IDLE;
      total_q <= 32'd0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.ap_start) begin
            count_q <= {CW{1'b0}};
            idle_q  <= 1'b0;
            state_q <= S_FIRE;
          end else begin
            idle_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_FIRE: begin
          if (fire) begin
            count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
            total_q <= total_q + 32'd1;
            state_q <= S_FIRE;
          end else begin
            ret_q   <= ret_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO strobes and data are combinational so a token moves in its fire cycle.
  always_comb begin
    bus.in_read   = fire;
    bus.out_write = fire;
    if (fire) begin
      bus.out_din = bus.in_dout + OFFSET;
    end else begin
      bus.out_din = {DATA_WIDTH{1'b0}};
    end
  end

  assign bus.ap_done       = done_q;
  assign bus.ap_ready      = done_q;
  assign bus.ap_idle       = idle_q;
  assign bus.ap_return     = ret_q;
  assign bus.total_firings = total_q;

endmodule
